neo_cmc_fixbank: RTL and testbench

Parametrised NEO-CMC fix-layer bank tracker that generalises the cartridge bankswitching logic to configurable bank width, line-map depth and column-table size. It snoops the LSPC fix-map fetch (VRAM address plus P-bus data) on each PCK2B strobe and drives the fix ROM bank select for the tile being fetched. It also adds synchronous reset, a sync pulse output and a current-line index output.

---
 rtl/neo_cmc_fixbank.sv | 190 +++++++++++++++++++
 tb/tb_neo_cmc_fixbank.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/neo_cmc_fixbank.sv
`default_nettype none
// ============================================================================
//  Module   : neo_cmc_fixbank
//  Purpose  : NEO-CMC fix-layer bank tracker. Snoops the LSPC fix-map fetch
//             (VRAM word address + P-bus data) on each PCK2B strobe and
//             drives the fix ROM bank select for the tile being fetched.
//             Supports a per-line bank map and a per-column bank table.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module neo_cmc_fixbank #(
  parameter int BANK_W    = 2,
  parameter int LINE_BITS = 5,
  parameter int COLS      = 40,
  parameter int SYNC_BANK = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 PCK2B_EN,
  input  logic [14:0]          PBUS,
  input  logic [10:0]          ADDR,
  input  logic [1:0]           MODE,
  output logic [BANK_W-1:0]    BANK,
  output logic                 SYNC,
  output logic [LINE_BITS-1:0] LINE
);

  // Entries carried by one 12-bit table write, and number of line-map slots.
  localparam int EPW   = 12 / BANK_W;
  localparam int LINES = 1 << LINE_BITS;

  localparam logic [1:0]        MODE_LINE   = 2'd1;
  localparam logic [1:0]        MODE_COL    = 2'd2;
  localparam logic [10:0]       SYNC_ADDR   = 11'h7E2;
  localparam logic [BANK_W-1:0] SYNC_BANK_V = BANK_W'(SYNC_BANK);

  // Registered state
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic                 sync_q, sync_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 skip_q, skip_d;
  logic                 primed_q, primed_d;
  logic [10:0]          old_addr_q, old_addr_d;
  logic                 map_en_q   [LINES];
  logic                 map_en_d   [LINES];
  logic                 map_vld_q  [LINES];
  logic                 map_vld_d  [LINES];
  logic [BANK_W-1:0]    map_bank_q [LINES];
  logic [BANK_W-1:0]    map_bank_d [LINES];
  logic [BANK_W-1:0]    tbl_q      [COLS];
  logic [BANK_W-1:0]    tbl_d      [COLS];

  // Decoded fetch attributes
  logic                 w_stable;
  logic                 w_sync;
  logic                 w_mode_off;
  logic                 w_lookup;
  logic                 w_map_wr;
  logic [LINE_BITS-1:0] w_map_idx;
  logic                 w_col_wr;
  int                   w_col_base;
  logic [5:0]           w_col_idx;
  logic [BANK_W-1:0]    w_col_rd;
  logic [11:0]          w_inv;
  logic [BANK_W-1:0]    w_slot [EPW];

  assign w_stable   = primed_q & (old_addr_q == ADDR);
  assign w_sync     = (ADDR == SYNC_ADDR) & (PBUS[14:12] == 3'd0);
  assign w_mode_off = (MODE != MODE_LINE) & (MODE != MODE_COL);
  // The sync word also sits in the 0x7xx lookup window; sync wins so a
  // stable sync fetch never consumes a map entry.
  assign w_lookup   = (ADDR[10:8] == 3'd7) & (PBUS[14:12] == 3'd0) & ~w_sync;
  assign w_map_wr   = (ADDR[10:8] == 3'd5) & ~ADDR[6] & ~ADDR[0];
  assign w_map_idx  = ADDR[LINE_BITS:1];
  assign w_col_wr   = (ADDR[10:8] == 3'd5) & (PBUS[14:12] == 3'd7);
  assign w_col_base = int'(ADDR[7:5]) * EPW;
  assign w_col_idx  = ADDR[10:5];
  assign w_inv      = ~PBUS[11:0];

  // Split the inverted P-bus word into EPW bank-sized slots.
  generate
    for (genvar k = 0; k < EPW; k++) begin : g_slot
      assign w_slot[k] = w_inv[k*BANK_W +: BANK_W];
    end
  endgenerate

  // Column table read; columns beyond the table select bank 0.
  always_comb begin
    w_col_rd = '0;
    if (int'(w_col_idx) < COLS) begin
      w_col_rd = tbl_q[w_col_idx];
    end
  end

  // Next-state logic: everything except the SYNC pulse holds without a strobe.
  always_comb begin
    bank_d     = bank_q;
    sync_d     = 1'b0;
    line_d     = line_q;
    skip_d     = skip_q;
    primed_d   = primed_q;
    old_addr_d = old_addr_q;
    map_en_d   = map_en_q;
    map_vld_d  = map_vld_q;
    map_bank_d = map_bank_q;
    tbl_d      = tbl_q;

    if (PCK2B_EN) begin
      old_addr_d = ADDR;
      primed_d   = 1'b1;

      if (w_sync) begin
        line_d = '0;
        skip_d = 1'b0;
        sync_d = 1'b1;
        bank_d = SYNC_BANK_V;
      end

      if (w_mode_off) begin
        bank_d = '0;
      end else if ((MODE == MODE_LINE) && w_stable) begin
        if (w_lookup) begin
          if (map_en_q[line_q] & map_vld_q[line_q] & ~skip_q) begin
            bank_d = map_bank_q[line_q];
            skip_d = 1'b1;
          end else begin
            line_d = line_q + 1'b1;
            skip_d = 1'b0;
          end
        end
        if (w_map_wr) begin
          if (ADDR[7]) begin
            map_vld_d[w_map_idx]  = &PBUS[11:8];
            map_bank_d[w_map_idx] = ~PBUS[BANK_W-1:0];
          end else begin
            map_en_d[w_map_idx] = (PBUS[11:0] == 12'h200);
          end
        end
      end else if ((MODE == MODE_COL) && w_stable) begin
        if (w_col_wr) begin
          for (int j = 0; j < COLS; j++) begin
            for (int k = 0; k < EPW; k++) begin
              if (j == w_col_base + k) begin
                tbl_d[j] = w_slot[k];
              end
            end
          end
        end
        // Read sees pre-write contents and overrides any sync bank load.
        bank_d = w_col_rd;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bank_q     <= '0;
      sync_q     <= 1'b0;
      line_q     <= '0;
      skip_q     <= 1'b0;
      primed_q   <= 1'b0;
      old_addr_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        map_en_q[i]   <= 1'b0;
        map_vld_q[i]  <= 1'b0;
        map_bank_q[i] <= '0;
      end
      for (int j = 0; j < COLS; j++) begin
        tbl_q[j] <= '0;
      end
    end else begin
      bank_q     <= bank_d;
      sync_q     <= sync_d;
      line_q     <= line_d;
      skip_q     <= skip_d;
      primed_q   <= primed_d;
      old_addr_q <= old_addr_d;
      map_en_q   <= map_en_d;
      map_vld_q  <= map_vld_d;
      map_bank_q <= map_bank_d;
      tbl_q      <= tbl_d;
    end
  end

  assign BANK = bank_q;
  assign SYNC = sync_q;
  assign LINE = line_q;

endmodule
`default_nettype wire

// File: tb/tb_neo_cmc_fixbank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neo_cmc_fixbank
//  Purpose  : Directed scoreboard bench for neo_cmc_fixbank. A default
//             instance and a LINE_BITS=1 instance share one stimulus stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_neo_cmc_fixbank;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PCK2B_EN;
  logic [14:0] PBUS;
  logic [10:0] ADDR;
  logic [1:0]  MODE;

  logic [1:0]  bank0;
  logic        sync0;
  logic [4:0]  line0;
  logic [1:0]  bank1;
  logic        sync1;
  logic [0:0]  line1;

  always #5 CLK = ~CLK;

  neo_cmc_fixbank dut (
    .CLK(CLK), .RESET(RESET), .PCK2B_EN(PCK2B_EN), .PBUS(PBUS), .ADDR(ADDR),
    .MODE(MODE), .BANK(bank0), .SYNC(sync0), .LINE(line0)
  );

  neo_cmc_fixbank #(.LINE_BITS(1)) dut_l1 (
    .CLK(CLK), .RESET(RESET), .PCK2B_EN(PCK2B_EN), .PBUS(PBUS), .ADDR(ADDR),
    .MODE(MODE), .BANK(bank1), .SYNC(sync1), .LINE(line1)
  );

  typedef struct {
    string      tag;
    logic [1:0] bank;
    logic       sync;
    logic [4:0] line;
    logic       chk1;
    logic       line1;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic check_out();
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=%0d want=1", sb.size());
    end else begin
      e = sb.pop_front();
      assert (bank0 === e.bank) else begin
        bad++;
        $error("FAIL %s.bank got=%0d want=%0d", e.tag, bank0, e.bank);
      end
      total++;
      assert (sync0 === e.sync) else begin
        bad++;
        $error("FAIL %s.sync got=%0d want=%0d", e.tag, sync0, e.sync);
      end
      total++;
      assert (line0 === e.line) else begin
        bad++;
        $error("FAIL %s.line got=%0d want=%0d", e.tag, line0, e.line);
      end
      if (e.chk1) begin
        total++;
        assert (line1 === e.line1) else begin
          bad++;
          $error("FAIL %s.line_l1 got=%0d want=%0d", e.tag, line1, e.line1);
        end
      end
    end
  endtask

  // Drive one cycle, record what the outputs must show after the edge, check.
  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [1:0] m, input logic [10:0] a,
                      input logic [14:0] p, input logic [1:0] eb,
                      input logic es, input logic [4:0] el,
                      input logic c1, input logic el1);
    exp_t e;
    @(negedge CLK);
    RESET    = rst;
    PCK2B_EN = en;
    MODE     = m;
    ADDR     = a;
    PBUS     = p;
    e.tag = tag; e.bank = eb; e.sync = es; e.line = el; e.chk1 = c1; e.line1 = el1;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    RESET = 1'b1; PCK2B_EN = 1'b0; MODE = 2'd0; ADDR = '0; PBUS = '0;

    // Reset with a strobe present and a sync word on the bus
    step("rst0", 1, 1, 2'd0, 11'h7E2, 15'h0000, 2'd0, 0, 5'd0, 1, 1'b0);
    step("rst1", 1, 1, 2'd0, 11'h7E2, 15'h0000, 2'd0, 0, 5'd0, 1, 1'b0);

    // Column mode: first strobe unprimed, second reads empty table[0]
    step("unprimed", 0, 1, 2'd2, 11'h000, 15'h0000, 2'd0, 0, 5'd0, 0, 1'b0);
    step("read0",    0, 1, 2'd2, 11'h000, 15'h0000, 2'd0, 0, 5'd0, 0, 1'b0);

    // Line mode, empty map: lookups advance LINE; 1-bit instance wraps
    step("wrap0", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd0, 0, 5'd0, 1, 1'b0);
    step("wrap1", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd0, 0, 5'd1, 1, 1'b1);
    step("wrap2", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd0, 0, 5'd2, 1, 1'b0);
    step("wrap3", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd0, 0, 5'd3, 1, 1'b1);
    step("wrap4", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd0, 0, 5'd4, 1, 1'b0);

    // Populate map[0]: enable, then valid with bank ~1 = 2
    step("men0", 0, 1, 2'd1, 11'h500, 15'h0200, 2'd0, 0, 5'd4, 0, 1'b0);
    step("men1", 0, 1, 2'd1, 11'h500, 15'h0200, 2'd0, 0, 5'd4, 0, 1'b0);
    step("mvl0", 0, 1, 2'd1, 11'h580, 15'h0F01, 2'd0, 0, 5'd4, 0, 1'b0);
    step("mvl1", 0, 1, 2'd1, 11'h580, 15'h0F01, 2'd0, 0, 5'd4, 0, 1'b0);

    // Sync: LINE to 0, bank SYNC_BANK, one-cycle pulse
    step("sync",   0, 1, 2'd1, 11'h7E2, 15'h0000, 2'd1, 1, 5'd0, 1, 1'b0);
    step("syncdn", 0, 0, 2'd1, 11'h7E2, 15'h0000, 2'd1, 0, 5'd0, 1, 1'b0);

    // Lookup: unstable, hit (skip set), then advance, then miss on line 1
    step("lk0", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd1, 0, 5'd0, 0, 1'b0);
    step("lk1", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd2, 0, 5'd0, 0, 1'b0);
    step("lk2", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd2, 0, 5'd1, 0, 1'b0);
    step("lk3", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd2, 0, 5'd2, 0, 1'b0);

    // Column write of entries 6..11 from 0xFE4; read of c=41 gives 0
    step("cw0", 0, 1, 2'd2, 11'h520, 15'h7FE4, 2'd2, 0, 5'd2, 0, 1'b0);
    step("cw1", 0, 1, 2'd2, 11'h520, 15'h7FE4, 2'd0, 0, 5'd2, 0, 1'b0);
    step("c6a", 0, 1, 2'd2, 11'h0C0, 15'h0000, 2'd0, 0, 5'd2, 0, 1'b0);
    step("c6b", 0, 1, 2'd2, 11'h0C0, 15'h0000, 2'd3, 0, 5'd2, 0, 1'b0);
    step("c7a", 0, 1, 2'd2, 11'h0E0, 15'h0000, 2'd3, 0, 5'd2, 0, 1'b0);
    step("c7b", 0, 1, 2'd2, 11'h0E0, 15'h0000, 2'd2, 0, 5'd2, 0, 1'b0);
    step("c8a", 0, 1, 2'd2, 11'h100, 15'h0000, 2'd2, 0, 5'd2, 0, 1'b0);
    step("c8b", 0, 1, 2'd2, 11'h100, 15'h0000, 2'd1, 0, 5'd2, 0, 1'b0);
    step("c63a", 0, 1, 2'd2, 11'h7E0, 15'h0000, 2'd1, 0, 5'd2, 0, 1'b0);
    step("c63b", 0, 1, 2'd2, 11'h7E0, 15'h0000, 2'd0, 0, 5'd2, 0, 1'b0);

    // Column mode sync: unstable loads SYNC_BANK, stable read overrides it
    step("csync0", 0, 1, 2'd2, 11'h7E2, 15'h0000, 2'd1, 1, 5'd0, 0, 1'b0);
    step("csync1", 0, 1, 2'd2, 11'h7E2, 15'h0000, 2'd0, 1, 5'd0, 0, 1'b0);

    // Mode off: bank forced 0, no lookup, no map write
    step("off0", 0, 1, 2'd0, 11'h700, 15'h0000, 2'd0, 0, 5'd0, 0, 1'b0);
    step("off1", 0, 1, 2'd0, 11'h700, 15'h0000, 2'd0, 0, 5'd0, 0, 1'b0);
    step("offw0", 0, 1, 2'd0, 11'h580, 15'h0F03, 2'd0, 0, 5'd0, 0, 1'b0);
    step("offw1", 0, 1, 2'd0, 11'h580, 15'h0F03, 2'd0, 0, 5'd0, 0, 1'b0);

    // Back to line mode: stored bank 2 still returned
    step("on0", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd0, 0, 5'd0, 0, 1'b0);
    step("on1", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd2, 0, 5'd0, 0, 1'b0);
    step("on2", 0, 1, 2'd1, 11'h700, 15'h0000, 2'd2, 0, 5'd1, 0, 1'b0);

    // Reset mid-line with a strobe and sync word present
    step("mrst", 1, 1, 2'd1, 11'h7E2, 15'h0000, 2'd0, 0, 5'd0, 1, 1'b0);

    // Map cleared: after sync, lookup misses and advances LINE
    step("psync", 0, 1, 2'd1, 11'h7E2, 15'h0000, 2'd1, 1, 5'd0, 1, 1'b0);
    step("plk0",  0, 1, 2'd1, 11'h700, 15'h0000, 2'd1, 0, 5'd0, 1, 1'b0);
    step("plk1",  0, 1, 2'd1, 11'h700, 15'h0000, 2'd1, 0, 5'd1, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
